// File: rtl/rr_sel_mux.sv
// M-channel to one-channel valid/ready mux with a single registered output stage.
// MODE 0 picks the channel named by sel; MODE 1 arbitrates round-robin among valid channels.
module rr_sel_mux #(
  parameter  int N    = 32,
  parameter  int M    = 4,
  parameter  int MODE = 0,
  localparam int S    = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  input  logic [S-1:0]   sel,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [S-1:0]   grant_id
);

  logic           can_load_s;
  logic           cand_ok_s;
  logic           cand_valid_s;
  logic [S-1:0]   cand_s;
  logic [N-1:0]   cand_data_s;
  logic [M-1:0]   ready_s;
  logic           xfer_s;

  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q,  out_data_d;
  logic [S-1:0]   grant_q,     grant_d;

  assign can_load_s = !out_valid_q || out_ready;

  generate
    if (MODE == 1) begin : g_rr
      logic [S-1:0] ptr_q, ptr_d;
      logic [S:0]   idx_s;

      // Round-robin search starting at ptr_q, first valid channel wins.
      always_comb begin
        cand_s       = '0;
        cand_valid_s = 1'b0;
        idx_s        = '0;
        for (int i = 0; i < M; i++) begin
          idx_s = {1'b0, ptr_q} + (S+1)'(i);
          if (idx_s >= (S+1)'(M)) begin
            idx_s = idx_s - (S+1)'(M);
          end else begin
            idx_s = idx_s;
          end
          if (!cand_valid_s && in_valid[idx_s[S-1:0]]) begin
            cand_s       = idx_s[S-1:0];
            cand_valid_s = 1'b1;
          end else begin
            cand_valid_s = cand_valid_s;
          end
        end
        cand_ok_s = cand_valid_s;
      end

      // Pointer moves past the winner only when a transfer actually happens.
      always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
          if (cand_s == S'(M-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = cand_s + 1'b1;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end

      // Pointer register.
      always_ff @(posedge clk) begin
        if (rst) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end else begin : g_sel
      // Explicit select; an out-of-range sel never offers ready and never transfers.
      always_comb begin
        cand_s       = sel;
        cand_ok_s    = 1'b0;
        cand_valid_s = 1'b0;
        if ({1'b0, sel} < (S+1)'(M)) begin
          cand_ok_s    = 1'b1;
          cand_valid_s = in_valid[sel];
        end else begin
          cand_ok_s    = 1'b0;
          cand_valid_s = 1'b0;
        end
      end
    end
  endgenerate

  // Data mux for the selected channel.
  always_comb begin
    cand_data_s = '0;
    for (int k = 0; k < M; k++) begin
      if (cand_s == S'(k)) begin
        cand_data_s = in_data[k*N +: N];
      end else begin
        cand_data_s = cand_data_s;
      end
    end
  end

  // Only the selected channel sees ready, and never during reset.
  always_comb begin
    ready_s = '0;
    if (!rst && cand_ok_s) begin
      ready_s[cand_s] = can_load_s;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s   = !rst && cand_ok_s && cand_valid_s && can_load_s;
  assign in_ready = ready_s;

  // Output stage next state: load on transfer, drain when consumed, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_d     = grant_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = cand_data_s;
      grant_d     = cand_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_q     <= grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Directed bench: two MODE 0 instances (M=4, M=3) and one MODE 1 instance (M=4), N=8.
module tb_rr_sel_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: MODE 0, M=4
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [1:0]  a_sel, a_gid;
  logic [7:0]  a_odata;
  logic        a_ovalid, a_oready;

  // Instance B: MODE 0, M=3
  logic [23:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic [1:0]  b_sel, b_gid;
  logic [7:0]  b_odata;
  logic        b_ovalid, b_oready;

  // Instance C: MODE 1, M=4
  logic [31:0] c_data;
  logic [3:0]  c_valid, c_ready;
  logic [1:0]  c_sel, c_gid;
  logic [7:0]  c_odata;
  logic        c_ovalid, c_oready;

  rr_sel_mux #(.N(8), .M(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .grant_id(a_gid));

  rr_sel_mux #(.N(8), .M(3), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready), .grant_id(b_gid));

  rr_sel_mux #(.N(8), .M(4), .MODE(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready), .grant_id(c_gid));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst      = 1'b1;
    a_data   = {8'h33, 8'hA5, 8'h22, 8'h11};
    b_data   = {8'h9C, 8'h9B, 8'h9A};
    c_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    a_valid  = 4'hF; b_valid = 3'h7; c_valid = 4'hF;
    a_sel    = 2'd0; b_sel = 2'd0; c_sel = 2'd3;
    a_oready = 1'b1; b_oready = 1'b1; c_oready = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 4'b0000);
    check("rst_b_ready", b_ready, 3'b000);
    check("rst_c_ready", c_ready, 4'b0000);
    tick(); tick();
    check("rst_a_ovalid", a_ovalid, 1'b0);
    check("rst_a_odata", a_odata, 8'h00);
    check("rst_c_ovalid", c_ovalid, 1'b0);
    check("rst_c_gid", c_gid, 2'd0);
    a_valid = 4'h0; b_valid = 3'h0; c_valid = 4'h0;
    rst = 1'b0;

    // A: basic select of channel 2
    a_sel = 2'd2; a_valid = 4'b0100;
    #1;
    check("a_sel2_ready", a_ready, 4'b0100);
    tick();
    check("a_sel2_ovalid", a_ovalid, 1'b1);
    check("a_sel2_odata", a_odata, 8'hA5);
    check("a_sel2_gid", a_gid, 2'd2);
    a_valid = 4'b0000;
    #1;
    check("a_ready_no_valid", a_ready, 4'b0100);
    tick();
    check("a_drain_ovalid", a_ovalid, 1'b0);

    // A: backpressure then simultaneous drain and load
    a_data = {8'h33, 8'h5A, 8'h77, 8'h11};
    a_valid = 4'b0100;
    tick();
    check("a_5a_odata", a_odata, 8'h5A);
    a_oready = 1'b0; a_sel = 2'd1; a_valid = 4'b0010;
    #1;
    check("a_bp_ready", a_ready, 4'b0000);
    tick();
    check("a_bp_odata", a_odata, 8'h5A);
    check("a_bp_gid", a_gid, 2'd2);
    check("a_bp_ovalid", a_ovalid, 1'b1);
    a_oready = 1'b1;
    #1;
    check("a_swap_ready", a_ready, 4'b0010);
    tick();
    check("a_swap_odata", a_odata, 8'h77);
    check("a_swap_gid", a_gid, 2'd1);
    check("a_swap_ovalid", a_ovalid, 1'b1);
    a_valid = 4'b0000;

    // B: out-of-range select on M=3
    b_sel = 2'd3; b_valid = 3'b111;
    #1;
    check("b_oor_ready", b_ready, 3'b000);
    tick();
    check("b_oor_ovalid", b_ovalid, 1'b0);
    b_sel = 2'd0;
    #1;
    check("b_sel0_ready", b_ready, 3'b001);
    tick();
    check("b_sel0_odata", b_odata, 8'h9A);
    b_valid = 3'b000;

    // C: round-robin with all channels valid
    c_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("c_rr_gid%0d", i), c_gid, rr_exp[i]);
      check($sformatf("c_rr_ovalid%0d", i), c_ovalid, 1'b1);
      check($sformatf("c_rr_odata%0d", i), c_odata, 8'hC0 + 8'(rr_exp[i]));
    end

    // C: backpressure holding ch1, pointer at 2
    c_oready = 1'b0;
    #1;
    check("c_bp_ready", c_ready, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c_bp_gid", c_gid, 2'd1);
      check("c_bp_odata", c_odata, 8'hC1);
    end
    c_oready = 1'b1;
    #1;
    check("c_resume_ready", c_ready, 4'b0100);
    tick();
    check("c_resume_gid", c_gid, 2'd2);

    // C: wrap from ch3 back to ch0
    c_valid = 4'b0001;
    tick();
    check("c_ptr1_gid", c_gid, 2'd0);
    c_valid = 4'b1001;
    #1;
    check("c_wrap_ready", c_ready, 4'b1000);
    tick();
    check("c_wrap_gid", c_gid, 2'd3);
    check("c_after_wrap_ready", c_ready, 4'b0001);
    tick();
    check("c_after_wrap_gid", c_gid, 2'd0);

    // C: reset mid-stream with ptr at 3
    c_valid = 4'b0100;
    tick();
    check("c_pre_rst_gid", c_gid, 2'd2);
    c_oready = 1'b0; c_valid = 4'b1111; rst = 1'b1;
    #1;
    check("c_rst_ready", c_ready, 4'b0000);
    tick();
    check("c_rst_ovalid", c_ovalid, 1'b0);
    check("c_rst_odata", c_odata, 8'h00);
    check("c_rst_gid", c_gid, 2'd0);
    rst = 1'b0; c_valid = 4'b0110; c_oready = 1'b1;
    #1;
    check("c_post_rst_ready", c_ready, 4'b0010);
    tick();
    check("c_post_rst_gid", c_gid, 2'd1);
    check("c_post_rst_odata", c_odata, 8'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
